// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - core/host arbiter for the shared external memory bus; optional ARB_FAIRNESS_EN starvation guard
module mem_bus_arbiter #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 8,
    parameter int WAIT_STATES    = 0,
    parameter int MAX_HOST_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_ack,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic              host_lock,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              grant_host
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [2:0]        wait_cnt;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              lat_we;
    logic              owner_host;
    logic              lock_flag;
    logic              grant_h;
    logic              grant_c;
    logic              force_core;
    logic              last_access;

    // The bus always shows the latched transaction; only the strobe is gated by state.
    assign mem_addr    = lat_addr;
    assign mem_wdata   = lat_wdata;
    assign grant_host  = owner_host;
    assign last_access = (wait_cnt == 3'd0);

`ifdef ARB_FAIRNESS_EN
    logic [7:0] starve_cnt;

    // Once the host has been granted MAX_HOST_BURST times over a waiting core, the core wins next.
    assign force_core = core_req && (starve_cnt == 8'(MAX_HOST_BURST));

    // Starvation counter: counts host grants that bypassed a waiting core.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= 8'd0;
        end else if (state == S_IDLE && ena) begin
            if (grant_c || !core_req) begin
                starve_cnt <= 8'd0;
            end else if (grant_h && starve_cnt != 8'hFF) begin
                starve_cnt <= starve_cnt + 8'd1;
            end
        end
    end
`else
    assign force_core = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, arbitration decision and per-state outputs.
    always_comb begin
        state_next = state;
        grant_h    = 1'b0;
        grant_c    = 1'b0;
        core_ack   = 1'b0;
        host_ack   = 1'b0;
        mem_we     = 1'b0;
        busy       = 1'b0;
        case (state)
            S_IDLE: begin
                if (ena) begin
                    if (force_core) begin
                        grant_c = 1'b1;
                    end else if (host_req) begin
                        grant_h = 1'b1;
                    end else if (core_req && !lock_flag) begin
                        grant_c = 1'b1;
                    end
                    if (grant_h || grant_c) begin
                        state_next = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                busy   = 1'b1;
                mem_we = lat_we;
                if (last_access) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                busy       = 1'b1;
                core_ack   = !owner_host;
                host_ack   = owner_host;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Latch the winner's transaction at the grant edge and count the access window down.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_we     <= 1'b0;
            owner_host <= 1'b0;
            wait_cnt   <= 3'd0;
        end else if (grant_h || grant_c) begin
            lat_addr   <= grant_h ? host_addr  : core_addr;
            lat_wdata  <= grant_h ? host_wdata : core_wdata;
            lat_we     <= grant_h ? host_we    : core_we;
            owner_host <= grant_h;
            wait_cnt   <= 3'(WAIT_STATES);
        end else if (state == S_ACCESS && !last_access) begin
            wait_cnt <= wait_cnt - 3'd1;
        end
    end

    // Read data is captured on the final access edge into the owner's register only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_rdata <= '0;
            host_rdata <= '0;
        end else if (state == S_ACCESS && last_access && !lat_we) begin
            if (owner_host) begin
                host_rdata <= mem_rdata;
            end else begin
                core_rdata <= mem_rdata;
            end
        end
    end

    // Host keeps the bus across a burst while it holds host_lock through its DONE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_flag <= 1'b0;
        end else if (state == S_DONE) begin
            lock_flag <= owner_host && host_lock;
        end else if (state == S_IDLE && !host_lock) begin
            lock_flag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - randomized self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

    localparam int WS   = 2;
    localparam int MAXB = 2;

    logic       clk = 1'b0;
    logic       rst_n, ena;
    logic       core_req, core_we, core_ack;
    logic [7:0] core_addr, core_wdata, core_rdata;
    logic       host_req, host_we, host_lock, host_ack;
    logic [7:0] host_addr, host_wdata, host_rdata;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_we, busy, grant_host;

    int checks   = 0;
    int failures = 0;

    logic [7:0] ram [256];
    logic [7:0] model_mem [256];
    logic [7:0] exp_core_rd = 8'h00;
    logic [7:0] exp_host_rd = 8'h00;
    logic       pl_we = 1'b0;
    logic [7:0] pl_addr = 8'h00;
    logic [7:0] pl_data = 8'h00;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .ADDR_W(8), .DATA_W(8), .WAIT_STATES(WS), .MAX_HOST_BURST(MAXB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_ack(core_ack), .core_rdata(core_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_lock(host_lock), .host_ack(host_ack),
        .host_rdata(host_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .busy(busy), .grant_host(grant_host)
    );

    // Simple asynchronous-read memory device on the bus, with a preload port.
    assign mem_rdata = ram[mem_addr];
    always @(posedge clk) begin
        if (pl_we) ram[pl_addr] <= pl_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
    end

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        pl_we = 1'b1; pl_addr = a; pl_data = d; model_mem[a] = d;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    // Issue up to one request per side at a negedge and observe until every issued request acks.
    task automatic run_pair(input bit hv, input bit hwe, input logic [7:0] ha, input logic [7:0] hd,
                            input bit cv, input bit cwe, input logic [7:0] ca, input logic [7:0] cd,
                            output int h_at, output int c_at, output logic [7:0] h_rd,
                            output logic [7:0] c_rd, output int we_cnt,
                            output logic [7:0] addr1, output logic [7:0] wdata1);
        h_at = -1; c_at = -1; h_rd = 8'h00; c_rd = 8'h00; we_cnt = 0; addr1 = 8'h00; wdata1 = 8'h00;
        host_req = hv; host_we = hwe; host_addr = ha; host_wdata = hd;
        core_req = cv; core_we = cwe; core_addr = ca; core_wdata = cd;
        for (int t = 1; t <= 40 && ((hv && h_at < 0) || (cv && c_at < 0)); t++) begin
            @(posedge clk); @(negedge clk);
            if (mem_we) we_cnt++;
            if (t == 1) begin addr1 = mem_addr; wdata1 = mem_wdata; end
            if (host_ack) begin h_at = t; h_rd = host_rdata; host_req = 1'b0; end
            if (core_ack) begin c_at = t; c_rd = core_rdata; core_req = 1'b0; end
        end
        host_req = 1'b0; core_req = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1;
        core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
        host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0; host_lock = 0;
        @(negedge clk);
        for (int i = 0; i < 256; i++) preload(8'(i), 8'($urandom));
        checks++;
        if ({core_ack, host_ack, mem_we, busy, grant_host} !== 5'b0) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=00000", {core_ack, host_ack, mem_we, busy, grant_host});
        end
        checks++;
        if ({core_rdata, host_rdata, mem_addr, mem_wdata} !== 32'h0) begin
            failures++; $display("FAIL reset_regs got=%h exp=00000000", {core_rdata, host_rdata, mem_addr, mem_wdata});
        end
        rst_n = 1'b1;
        @(negedge clk); @(negedge clk);
        checks++;
        if ({busy, core_ack, host_ack} !== 3'b0) begin
            failures++; $display("FAIL reset_idle got=%b exp=000", {busy, core_ack, host_ack});
        end
    endtask

    task automatic test_core_read();
        int h_at, c_at, wc; logic [7:0] hr, cr, a1, d1;
        preload(8'h10, 8'h5A);
        run_pair(0, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00, h_at, c_at, hr, cr, wc, a1, d1);
        exp_core_rd = 8'h5A;
        checks++; if (c_at !== WS + 2) begin failures++; $display("FAIL core_read_lat got=%0d exp=%0d", c_at, WS + 2); end
        checks++; if (cr !== exp_core_rd) begin failures++; $display("FAIL core_read_data got=%h exp=%h", cr, exp_core_rd); end
        checks++; if (a1 !== 8'h10) begin failures++; $display("FAIL core_read_addr got=%h exp=10", a1); end
        checks++; if (wc !== 0) begin failures++; $display("FAIL core_read_we got=%0d exp=0", wc); end
        checks++; if (host_rdata !== exp_host_rd) begin failures++; $display("FAIL core_read_hostrd got=%h exp=%h", host_rdata, exp_host_rd); end
    endtask

    task automatic test_host_write();
        int h_at, c_at, wc; logic [7:0] hr, cr, a1, d1;
        run_pair(1, 1, 8'h03, 8'hC4, 0, 0, 8'h00, 8'h00, h_at, c_at, hr, cr, wc, a1, d1);
        model_mem[8'h03] = 8'hC4;
        checks++; if (h_at !== WS + 2) begin failures++; $display("FAIL host_write_lat got=%0d exp=%0d", h_at, WS + 2); end
        checks++; if (wc !== WS + 1) begin failures++; $display("FAIL host_write_we_cycles got=%0d exp=%0d", wc, WS + 1); end
        checks++; if ({a1, d1} !== 16'h03C4) begin failures++; $display("FAIL host_write_bus got=%h exp=03c4", {a1, d1}); end
        checks++; if (hr !== exp_host_rd) begin failures++; $display("FAIL host_write_rdata got=%h exp=%h", hr, exp_host_rd); end
        run_pair(0, 0, 8'h00, 8'h00, 1, 0, 8'h03, 8'h00, h_at, c_at, hr, cr, wc, a1, d1);
        exp_core_rd = model_mem[8'h03];
        checks++; if (cr !== exp_core_rd) begin failures++; $display("FAIL host_write_readback got=%h exp=%h", cr, exp_core_rd); end
    endtask

    task automatic test_simultaneous();
        int h_at, c_at, wc; logic [7:0] hr, cr, a1, d1, ha, ca;
        ha = 8'($urandom); ca = 8'($urandom);
        run_pair(1, 0, ha, 8'h00, 1, 0, ca, 8'h00, h_at, c_at, hr, cr, wc, a1, d1);
        exp_host_rd = model_mem[ha]; exp_core_rd = model_mem[ca];
        checks++; if (h_at !== WS + 2) begin failures++; $display("FAIL simul_host_lat got=%0d exp=%0d", h_at, WS + 2); end
        checks++; if (c_at !== 2 * WS + 5) begin failures++; $display("FAIL simul_core_lat got=%0d exp=%0d", c_at, 2 * WS + 5); end
        checks++; if ({hr, cr} !== {exp_host_rd, exp_core_rd}) begin
            failures++; $display("FAIL simul_rdata got=%h exp=%h", {hr, cr}, {exp_host_rd, exp_core_rd});
        end
    endtask

    task automatic test_random();
        int h_at, c_at, wc, eh, ec, ewc; logic [7:0] hr, cr, a1, d1, ha, hd, ca, cd;
        bit hv, cv, hwe, cwe; int mode;
        for (int n = 0; n < 30; n++) begin
            mode = int'($urandom_range(0, 2));
            hv = (mode != 1); cv = (mode != 0);
            hwe = 1'($urandom); cwe = 1'($urandom);
            ha = 8'($urandom_range(0, 15)); ca = 8'($urandom_range(0, 15));
            hd = 8'($urandom); cd = 8'($urandom);
            run_pair(hv, hwe, ha, hd, cv, cwe, ca, cd, h_at, c_at, hr, cr, wc, a1, d1);
            // Transaction-level model: host first, then core, each sees the memory as left by the previous.
            if (hv) begin if (hwe) model_mem[ha] = hd; else exp_host_rd = model_mem[ha]; end
            if (cv) begin if (cwe) model_mem[ca] = cd; else exp_core_rd = model_mem[ca]; end
            eh  = hv ? WS + 2 : -1;
            ec  = cv ? (hv ? 2 * WS + 5 : WS + 2) : -1;
            ewc = ((hv && hwe) ? WS + 1 : 0) + ((cv && cwe) ? WS + 1 : 0);
            checks++; if (h_at !== eh) begin failures++; $display("FAIL rand_host_lat[%0d] got=%0d exp=%0d", n, h_at, eh); end
            checks++; if (c_at !== ec) begin failures++; $display("FAIL rand_core_lat[%0d] got=%0d exp=%0d", n, c_at, ec); end
            checks++; if (wc !== ewc) begin failures++; $display("FAIL rand_we_cycles[%0d] got=%0d exp=%0d", n, wc, ewc); end
            checks++; if ({host_rdata, core_rdata} !== {exp_host_rd, exp_core_rd}) begin
                failures++; $display("FAIL rand_rdata[%0d] got=%h exp=%h", n, {host_rdata, core_rdata}, {exp_host_rd, exp_core_rd});
            end
        end
    endtask

    task automatic test_ena();
        int at; bit bad; logic [7:0] d;
        ena = 1'b0; core_req = 1; core_we = 0; core_addr = 8'h60; bad = 0;
        repeat (4) begin @(posedge clk); @(negedge clk); if (busy || core_ack) bad = 1; end
        checks++; if (bad !== 1'b0) begin failures++; $display("FAIL ena_block got=%b exp=0", bad); end
        ena = 1'b1; at = -1;
        for (int t = 1; t <= 20 && at < 0; t++) begin @(posedge clk); @(negedge clk); if (core_ack) at = t; end
        exp_core_rd = model_mem[8'h60];
        checks++; if (at !== WS + 2) begin failures++; $display("FAIL ena_resume_lat got=%0d exp=%0d", at, WS + 2); end
        checks++; if (core_rdata !== exp_core_rd) begin failures++; $display("FAIL ena_resume_data got=%h exp=%h", core_rdata, exp_core_rd); end
        core_req = 0;
        @(posedge clk); @(negedge clk);
        d = 8'($urandom);
        host_req = 1; host_we = 1; host_addr = 8'h61; host_wdata = d; model_mem[8'h61] = d;
        core_req = 1; core_we = 0; core_addr = 8'h62;
        @(posedge clk); @(negedge clk);
        ena = 1'b0; at = -1;
        for (int t = 2; t <= 20 && at < 0; t++) begin @(posedge clk); @(negedge clk); if (host_ack) at = t; end
        checks++; if (at !== WS + 2) begin failures++; $display("FAIL ena_drop_complete got=%0d exp=%0d", at, WS + 2); end
        host_req = 0; bad = 0;
        repeat (4) begin @(posedge clk); @(negedge clk); if (busy || core_ack) bad = 1; end
        checks++; if (bad !== 1'b0) begin failures++; $display("FAIL ena_drop_nogrant got=%b exp=0", bad); end
        ena = 1'b1; at = -1;
        for (int t = 1; t <= 20 && at < 0; t++) begin @(posedge clk); @(negedge clk); if (core_ack) at = t; end
        exp_core_rd = model_mem[8'h62];
        checks++; if (at !== WS + 2 || core_rdata !== exp_core_rd) begin
            failures++; $display("FAIL ena_core_after got=%0d/%h exp=%0d/%h", at, core_rdata, WS + 2, exp_core_rd);
        end
        core_req = 0;
        @(posedge clk); @(negedge clk);
    endtask

`ifndef ARB_FAIRNESS_EN
    task automatic test_lock();
        int at; bit core_seen, busy_gap; logic [7:0] d;
        core_seen = 0; busy_gap = 0;
        core_req = 1; core_we = 0; core_addr = 8'h20; core_wdata = 0; host_lock = 1;
        for (int k = 0; k < 3; k++) begin
            d = 8'($urandom);
            host_req = 1; host_we = 1; host_addr = 8'h30 + 8'(k); host_wdata = d; model_mem[host_addr] = d;
            at = -1;
            for (int t = 1; t <= 20 && at < 0; t++) begin
                @(posedge clk); @(negedge clk);
                if (core_ack) core_seen = 1;
                if (host_ack) at = t;
            end
            checks++; if (at !== WS + 2) begin failures++; $display("FAIL lock_host_lat[%0d] got=%0d exp=%0d", k, at, WS + 2); end
            host_req = 0;
            repeat (3) begin @(posedge clk); @(negedge clk); if (core_ack) core_seen = 1; if (busy) busy_gap = 1; end
        end
        checks++; if (core_seen !== 1'b0) begin failures++; $display("FAIL lock_core_blocked got=%b exp=0", core_seen); end
        checks++; if (busy_gap !== 1'b0) begin failures++; $display("FAIL lock_gap_idle got=%b exp=0", busy_gap); end
        host_lock = 0; at = -1;
        for (int t = 1; t <= 20 && at < 0; t++) begin @(posedge clk); @(negedge clk); if (core_ack) at = t; end
        exp_core_rd = model_mem[8'h20];
        checks++; if (at != WS + 2 && at != WS + 3) begin failures++; $display("FAIL lock_release_lat got=%0d exp=%0d..%0d", at, WS + 2, WS + 3); end
        checks++; if (core_rdata !== exp_core_rd) begin failures++; $display("FAIL lock_release_data got=%h exp=%h", core_rdata, exp_core_rd); end
        core_req = 0;
        @(posedge clk); @(negedge clk);
    endtask
`else
    task automatic test_fairness();
        int n; logic [3:0] seq;
        n = 0; seq = 4'b0;
        host_req = 1; host_lock = 1; host_we = 1; host_addr = 8'h50; host_wdata = 8'($urandom);
        core_req = 1; core_we = 0; core_addr = 8'h40;
        for (int t = 1; t <= 80 && n < 4; t++) begin
            @(posedge clk); @(negedge clk);
            if (host_ack) begin
                seq[n] = 1'b1; n++;
                model_mem[host_addr] = host_wdata;
                host_addr = host_addr + 8'd1; host_wdata = 8'($urandom);
                if (n == 4) begin host_req = 0; host_lock = 0; end
            end else if (core_ack) begin
                seq[n] = 1'b0; n++;
                exp_core_rd = model_mem[8'h40];
                core_req = 0;
            end
        end
        host_req = 0; host_lock = 0; core_req = 0;
        checks++; if (n !== 4 || seq !== 4'b1011) begin failures++; $display("FAIL fair_order got=%0d/%b exp=4/1011", n, seq); end
        checks++; if (core_rdata !== exp_core_rd) begin failures++; $display("FAIL fair_core_data got=%h exp=%h", core_rdata, exp_core_rd); end
        @(posedge clk); @(negedge clk);
    endtask
`endif

    task automatic test_reset_mid();
        int h_at, c_at, wc; logic [7:0] hr, cr, a1, d1;
        host_req = 1; host_we = 1; host_addr = 8'h70; host_wdata = model_mem[8'h70];
        @(posedge clk); @(negedge clk);
        checks++; if ({busy, mem_we} !== 2'b11) begin failures++; $display("FAIL rstmid_access got=%b exp=11", {busy, mem_we}); end
        @(posedge clk); @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if ({mem_we, busy, host_ack, core_ack, grant_host} !== 5'b0) begin
            failures++; $display("FAIL rstmid_abort got=%b exp=00000", {mem_we, busy, host_ack, core_ack, grant_host});
        end
        exp_core_rd = 8'h00; exp_host_rd = 8'h00;
        host_req = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_pair(0, 0, 8'h00, 8'h00, 1, 0, 8'h71, 8'h00, h_at, c_at, hr, cr, wc, a1, d1);
        exp_core_rd = model_mem[8'h71];
        checks++; if (h_at !== -1) begin failures++; $display("FAIL rstmid_no_host_ack got=%0d exp=-1", h_at); end
        checks++; if (c_at !== WS + 2 || cr !== exp_core_rd) begin
            failures++; $display("FAIL rstmid_fresh_read got=%0d/%h exp=%0d/%h", c_at, cr, WS + 2, exp_core_rd);
        end
        checks++; if (host_rdata !== exp_host_rd) begin failures++; $display("FAIL rstmid_hostrd got=%h exp=%h", host_rdata, exp_host_rd); end
    endtask

    initial begin
        test_reset();
        test_core_read();
        test_host_write();
        test_simultaneous();
        test_ena();
`ifndef ARB_FAIRNESS_EN
        test_lock();
`else
        test_fairness();
`endif
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
